// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of a single synchronous data memory
// One command in flight at a time: arbitrate in IDLE, drive memory in ISSUE, wait out read latency.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int READ_LAT   = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              r0_req_i,
  input  logic              r0_we_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_wdata_i,
  output logic              r0_gnt_o,
  output logic              r0_rvalid_o,
  output logic [DATA_W-1:0] r0_rdata_o,
  input  logic              r1_req_i,
  input  logic              r1_we_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_wdata_i,
  output logic              r1_gnt_o,
  output logic              r1_rvalid_o,
  output logic [DATA_W-1:0] r1_rdata_o,
  output logic              mem_en_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_e;

  localparam logic [2:0] LAT_LOAD = 3'(READ_LAT - 1);
  localparam bit         FIXED    = (FIXED_PRIO != 0);

  state_e              state_q, state_d;
  logic                winner_q, winner_d;
  logic                rr_last_q, rr_last_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                pick_r1;
  logic                rvalid_now;

  // Port 1 wins alone, or on a tie when round-robin says port 0 went last.
  assign pick_r1 = r1_req_i & (~r0_req_i | (~FIXED & ~rr_last_q));

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    rr_last_d   = rr_last_q;
    cnt_d       = cnt_q;
    mem_en_d    = mem_en_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (r0_req_i || r1_req_i) begin
          winner_d    = pick_r1;
          mem_en_d    = 1'b1;
          mem_wen_d   = pick_r1 ? r1_we_i    : r0_we_i;
          mem_addr_d  = pick_r1 ? r1_addr_i  : r0_addr_i;
          mem_wdata_d = pick_r1 ? r1_wdata_i : r0_wdata_i;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        rr_last_d = winner_q;
        mem_en_d  = 1'b0;
        mem_wen_d = 1'b0;
        if (mem_wen_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      winner_q    <= 1'b0;
      rr_last_q   <= 1'b1;
      cnt_q       <= 3'd0;
      mem_en_q    <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      rr_last_q   <= rr_last_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign rvalid_now  = (state_q == WAIT) && (cnt_q == 3'd0);
  assign r0_gnt_o    = (state_q == ISSUE) && !winner_q;
  assign r1_gnt_o    = (state_q == ISSUE) &&  winner_q;
  assign r0_rvalid_o = rvalid_now && !winner_q;
  assign r1_rvalid_o = rvalid_now &&  winner_q;
  assign r0_rdata_o  = r0_rvalid_o ? mem_rdata_i : '0;
  assign r1_rdata_o  = r1_rvalid_o ? mem_rdata_i : '0;
  assign mem_en_o    = mem_en_q;
  assign mem_wen_o   = mem_wen_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = (state_q != IDLE);

endmodule
